// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Time-multiplexed driver for a 4-digit common-anode hex display fed by the
// processor's 16-bit routa debug bus. A snapshot of the input is reloaded once
// per full scan (unless held) so the digits stay stable while routa changes.
//
// Ports:
//   clk      in   system clock
//   reset    in   synchronous active-low reset
//   data_in  in   16-bit value to display
//   dp_en    in   per-digit decimal-point enable (bit i = digit i)
//   hold     in   1 = freeze the snapshot at scan boundaries
//   seg      out  segment cathodes {g,f,e,d,c,b,a}, active-low
//   dp       out  decimal-point cathode, active-low
//   an       out  digit anodes, active-low, bit 0 = least-significant digit
//   changed  out  one-cycle pulse when a snapshot load alters the stored value
module seg7_scan_driver #(
  parameter logic [15:0] REFRESH_DIV   = 16'd50000,
  parameter logic [15:0] BLANK_CYCLES  = 16'd500,
  parameter bit          LEADING_BLANK = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] data_in,
  input  logic [3:0]  dp_en,
  input  logic        hold,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        changed
);

  localparam int unsigned DataW = 16;
  localparam int unsigned DigW  = 2;
  localparam int unsigned NumD  = 4;
  localparam int unsigned SegW  = 7;

  localparam logic [DataW-1:0] PcLast    = REFRESH_DIV - 16'd1;
  localparam logic [DataW-1:0] ActiveLen = REFRESH_DIV - BLANK_CYCLES;

  // Hex font, active-high {g..a}
  function automatic logic [SegW-1:0] hex_font(input logic [3:0] n);
    logic [SegW-1:0] f;
    case (n)
      4'h0: f = 7'h3F;
      4'h1: f = 7'h06;
      4'h2: f = 7'h5B;
      4'h3: f = 7'h4F;
      4'h4: f = 7'h66;
      4'h5: f = 7'h6D;
      4'h6: f = 7'h7D;
      4'h7: f = 7'h07;
      4'h8: f = 7'h7F;
      4'h9: f = 7'h6F;
      4'hA: f = 7'h77;
      4'hB: f = 7'h7C;
      4'hC: f = 7'h39;
      4'hD: f = 7'h5E;
      4'hE: f = 7'h79;
      default: f = 7'h71;
    endcase
    return f;
  endfunction

  logic [DataW-1:0] pc_q, pc_d;
  logic [DigW-1:0]  d_q, d_d;
  logic [DataW-1:0] snap_q, snap_d;
  logic [NumD-1:0]  snap_dp_q, snap_dp_d;
  logic [NumD-1:0]  an_q, an_d;
  logic [SegW-1:0]  seg_q, seg_d;
  logic             dp_q, dp_d;
  logic             changed_q, changed_d;

  logic             wrap;
  logic             load;
  logic [3:0]       nibble;
  logic             nz3, nz2, nz1;
  logic             lit;
  logic             on;

  // Next state and output decode; outputs are derived from the current state
  // so they show up one cycle later.
  always_comb begin
    pc_d      = pc_q + 16'd1;
    d_d       = d_q;
    snap_d    = snap_q;
    snap_dp_d = snap_dp_q;
    changed_d = 1'b0;
    an_d      = 4'hF;
    seg_d     = 7'h7F;
    dp_d      = 1'b1;
    lit       = 1'b1;

    wrap = (pc_q == PcLast);
    load = wrap && (d_q == 2'd3) && !hold;

    if (wrap) begin
      pc_d = '0;
      d_d  = d_q + 2'd1;
    end

    // Scan-boundary reload takes this cycle's data_in
    if (load) begin
      snap_d    = data_in;
      snap_dp_d = dp_en;
      changed_d = (data_in != snap_q);
    end

    nibble = snap_q[{d_q, 2'b00} +: 4];

    // A digit is significant if it or any higher nibble is non-zero
    nz3 = |snap_q[15:12];
    nz2 = nz3 | (|snap_q[11:8]);
    nz1 = nz2 | (|snap_q[7:4]);

    if (LEADING_BLANK) begin
      case (d_q)
        2'd1:    lit = nz1;
        2'd2:    lit = nz2;
        2'd3:    lit = nz3;
        default: lit = 1'b1;
      endcase
    end

    on = lit && (pc_q < ActiveLen);

    if (on) begin
      an_d  = ~(4'b0001 << d_q);
      seg_d = ~hex_font(nibble);
      dp_d  = ~snap_dp_q[d_q];
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q      <= '0;
      d_q       <= '0;
      snap_q    <= '0;
      snap_dp_q <= '0;
      an_q      <= 4'hF;
      seg_q     <= 7'h7F;
      dp_q      <= 1'b1;
      changed_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      d_q       <= d_d;
      snap_q    <= snap_d;
      snap_dp_q <= snap_dp_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      changed_q <= changed_d;
    end
  end

  assign an      = an_q;
  assign seg     = seg_q;
  assign dp      = dp_q;
  assign changed = changed_q;

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Downstream consumer of the processor's 16-bit `routa` debug output. Drives a 4-digit, common-anode seven-segment display on the board. The value is shown as four hexadecimal digits by time-multiplexing the anodes. A snapshot register keeps the display stable while the core updates `routa` every cycle; it reloads once per full scan unless frozen.

## Interface
- `REFRESH_DIV`, 16'd50000: clock cycles each digit is selected. Must be ≥ 2.
- `BLANK_CYCLES`, 16'd500: cycles at the end of each digit slot with all anodes off, for anti-ghosting. Must be < `REFRESH_DIV`.
- `LEADING_BLANK`, 1: 1 = suppress leading zero digits; 0 = always show all four.
- `clk`  in  1  system clock, the same clock as the processor.
- `reset`  in  1  synchronous, active-low reset. Sampled only on rising `clk`.
- `data_in`  in  16  value to display (`routa`).
- `dp_en`  in  4  per-digit decimal-point enable. Bit i goes with digit i.
- `hold`  in  1  1 = freeze the snapshot; the display keeps scanning.
- `seg`  out  7  segment cathodes {g,f,e,d,c,b,a}, active-low.
- `dp`  out  1  decimal-point cathode, active-low.
- `an`  out  4  digit anodes, active-low. Bit 0 = least-significant hex digit.
- `changed`  out  1  one-cycle pulse when a snapshot load alters the stored value.

## Operation
- State:
  - prescaler `pc` counts 0..`REFRESH_DIV`-1, then wraps to 0.
  - digit index `d` (2 bits).
  - snapshot `snap[15:0]`.
  - `snap_dp[3:0]`.
- Each cycle `pc` increments. When `pc`=`REFRESH_DIV`-1:
  - `pc` goes to 0 and `d` goes to `d`+1 mod 4 (3 wraps to 0).
  - Scan-boundary load: if also `d`=3 and `hold`=0, then `snap`←`data_in` and `snap_dp`←`dp_en`. These are the values present in that same cycle.
  - `changed` asserts on the next cycle iff the loaded `data_in` ≠ the old `snap`.
- Active window: `pc` < `REFRESH_DIV`-`BLANK_CYCLES`. Outside it all anodes are off.
- Nibble select: digit i shows `snap[4i+3:4i]`.
- Leading blank (`LEADING_BLANK`=1):
  - Digit 3 is blank iff nibble3=0.
  - Digit 2 is blank iff nibbles 3..2 are all 0.
  - Digit 1 is blank iff nibbles 3..1 are all 0.
  - Digit 0 is never blanked.
  - A blanked digit has its anode off.
- Decimal point: `dp`=~`snap_dp[d]` when that digit's anode is on, else 1.
- Hex font, active-high {g..a}, driven inverted on `seg`:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- `an`=~(4'b0001<<`d`) when the digit is active and not blanked, else 4'b1111.
- When the anode is off, `seg`=7'h7F.

## Timing
- Reset values, all applied at the first rising edge with `reset`=0:
  - `pc`=0, `d`=0, `snap`=0, `snap_dp`=0.
  - `an`=4'hF, `seg`=7'h7F, `dp`=1, `changed`=0.
- Reset asserted mid-scan or mid-blank returns every state and output to these values at that edge. No partial slot is completed.
- `an`/`seg`/`dp`/`changed` are registered and reflect the `pc`/`d`/`snap` state of the previous cycle (1-cycle latency).
- First cycle after reset release: internal state is `d`=0, `pc`=0, `snap`=0. On the following cycle the outputs become `an`=4'b1110, `seg`=7'h40 ("0"), `dp`=1.
- Display latency from `data_in` to visible digit: up to 4·`REFRESH_DIV`+1 cycles.
- `hold` is sampled only at the scan-boundary cycle. `hold` pulses that do not cover a boundary have no effect.
- A `data_in` change in the same cycle as the load is captured: the load takes the current-cycle value.
- `changed` never asserts while `hold`=1, and never on a load of an identical value.
- Full scan period: 4·`REFRESH_DIV` cycles. Each anode is on for `REFRESH_DIV`-`BLANK_CYCLES` cycles per period.

## Test plan
- Reset with `REFRESH_DIV`=4, `BLANK_CYCLES`=1, `data_in`=16'h1234, `reset` low for 3 cycles:
  - During reset: `an`=F, `seg`=7F, `dp`=1.
  - First scan after release shows "0" on digit 0 only, with digits 1–3 dark.
  - After the first boundary the digits show 4, 3, 2, 1: `an`=E, D, B, 7 with `seg`=19, 30, 24, 79 respectively. Each is on for 3 cycles and then off (4'hF) for 1 cycle.
- `data_in`=16'h00A0 with `LEADING_BLANK`=1:
  - Digits 3 and 2 are dark, digit 1 shows `seg`=08 ("A"), digit 0 shows `seg`=40.
  - Repeat with `LEADING_BLANK`=0: all four digits lit; digits 3 and 2 show `seg`=40.
- Load 16'hBEEF, then raise `hold` and change `data_in` to 16'h0001 for 3 scans:
  - The display stays BEEF and `changed` stays 0.
  - Drop `hold`: at the next boundary the display becomes 0001 and `changed` pulses for exactly 1 cycle.
- Same value reloaded, 16'h5555 on two consecutive boundaries: `changed` pulses only after the first load.
- `dp_en`=4'b0100: `dp`=0 only while `an`=4'b1011 is active; otherwise `dp`=1, including during blank cycles.
- Assert `reset` while `d`=2, `pc`=2: on the next edge all outputs and state return to their reset values, and scanning restarts from digit 0.
